// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, FSM states and datapath mux/ALU select codes.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_OLD_PC = 2'b01;
  localparam logic [1:0] A_RS1    = 2'b10;

  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Opcodes that have an EX state (ECALL is resolved in ID)
  function automatic logic has_ex(input logic [6:0] op);
    return (op == OP_ARITH) || (op == OP_ARITH_IMM) ||
           (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) ||
           (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait watchdog: counts cycles without mem_ready while
// a request is outstanding. LIMIT=0 disables it entirely.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic mem_ready,
  output logic expire
);

  if (LIMIT > 0) begin : g_timer
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + W'(1);

    always_ff @(posedge clk) begin
      if (!reset_n || !active || mem_ready)
        cnt <= '0;
      else
        cnt <= cnt_inc;
    end

    // mem_ready on the limit cycle still completes the access
    assign expire = active && !mem_ready &&
                    (cnt_inc == W'(LIMIT));
  end else begin : g_none
    logic unused;
    assign unused = ^{clk, reset_n, active, mem_ready};
    assign expire = 1'b0;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/BR/HALT).
// Optional perf counters: define CTRL_PERF_CNT_EN.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                bcond,
  input  logic                halt_req,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                is_ecall,
  output logic                halted,
  output logic                illegal_inst,
  output logic                mem_error,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instret
);

  state_t state, next;
  logic illegal_q, mem_error_q;
  logic set_illegal, set_timeout;
  logic wait_active, expire;
  logic pcw, irw, iod, mrd, mwr, rwr, ecl;
  logic [1:0] wb, sa, sb, op;

  assign wait_active = (state == S_IF) || (state == S_MEM);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .active    (wait_active),
    .mem_ready (mem_ready),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IF;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state <= next;
      if (set_illegal) illegal_q   <= 1'b1;
      if (set_timeout) mem_error_q <= 1'b1;
    end
  end

  always_comb begin
    next        = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pcw = 1'b0; irw = 1'b0; iod = 1'b0;
    mrd = 1'b0; mwr = 1'b0; rwr = 1'b0;
    ecl = 1'b0;
    wb = WB_ALU; sa = A_PC; sb = B_RS2; op = ALU_ADD;
    unique case (state)
      S_IF: begin
        mrd = 1'b1;
        sb  = B_FOUR;
        if (mem_ready) begin
          irw  = 1'b1;
          pcw  = 1'b1;
          next = S_ID;
        end else if (expire) begin
          set_timeout = 1'b1;
          next        = S_HALT;
        end
      end
      S_ID: begin
        if (opcode == OP_ECALL) begin
          ecl  = 1'b1;
          next = halt_req ? S_HALT : S_IF;
        end else if (has_ex(opcode)) begin
          next = S_EX;
        end else begin
          set_illegal = 1'b1;
          next        = S_HALT;
        end
      end
      S_EX: begin
        sa = A_RS1;
        case (opcode)
          OP_ARITH: begin
            op = ALU_FUNCT; next = S_WB;
          end
          OP_ARITH_IMM: begin
            sb = B_IMM; op = ALU_FUNCT; next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            sb = B_IMM; next = S_MEM;
          end
          OP_BRANCH: begin
            op   = ALU_BR;
            next = bcond ? S_BR : S_IF;
          end
          OP_JAL, OP_JALR: begin
            if (opcode == OP_JAL) sa = A_OLD_PC;
            sb  = B_IMM;
            pcw = 1'b1;
            rwr = 1'b1;
            wb  = WB_PC;
            next = S_IF;
          end
          default: begin
            set_illegal = 1'b1;
            next        = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        sa  = A_RS1;
        sb  = B_IMM;
        iod = 1'b1;
        mrd = (opcode == OP_LOAD);
        mwr = (opcode == OP_STORE);
        if (mem_ready) begin
          next = (opcode == OP_LOAD) ? S_WB : S_IF;
        end else if (expire) begin
          set_timeout = 1'b1;
          next        = S_HALT;
        end
      end
      S_WB: begin
        rwr  = 1'b1;
        wb   = (opcode == OP_LOAD) ? WB_MDR : WB_ALU;
        next = S_IF;
      end
      S_BR: begin
        sa   = A_OLD_PC;
        sb   = B_IMM;
        pcw  = 1'b1;
        next = S_IF;
      end
      S_HALT: next = S_HALT;
      default: next = S_HALT;
    endcase
  end

  // Reset masks every output so an aborted instruction has no side effect
  assign pc_write     = reset_n & pcw;
  assign ir_write     = reset_n & irw;
  assign i_or_d       = reset_n & iod;
  assign mem_read     = reset_n & mrd;
  assign mem_write    = reset_n & mwr;
  assign reg_write    = reset_n & rwr;
  assign is_ecall     = reset_n & ecl;
  assign wb_sel       = reset_n ? wb : 2'b00;
  assign alu_src_a    = reset_n ? sa : 2'b00;
  assign alu_src_b    = reset_n ? sb : 2'b00;
  assign alu_op       = reset_n ? op : 2'b00;
  assign halted       = reset_n & (state == S_HALT);
  assign illegal_inst = reset_n & illegal_q;
  assign mem_error    = reset_n & mem_error_q;
  assign state_o      = reset_n ? state : 3'd0;

`ifdef CTRL_PERF_CNT_EN
  logic retire;
  logic [CNT_W-1:0] cyc_q, ret_q;

  assign retire = (state != S_IF) && (next == S_IF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)          ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_count = reset_n ? cyc_q : '0;
  assign instret     = reset_n ? ret_q : '0;
`else
  assign cycle_count = '0;
  assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_TIMEOUT=4).
// Counter checks follow CTRL_PERF_CNT_EN.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, iod, mr, mw, rw;
    logic [1:0] wb, a, b, op;
    logic ec, hlt, ill, merr;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] opcode;
  logic bcond, halt_req, mem_ready;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic reg_write, is_ecall, halted, illegal_inst, mem_error;
  logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
  logic [2:0] state_o;
  logic [CNT_W-1:0] cycle_count, instret;

  int errors = 0;
  int checks = 0;

  ctl_t obs;
  ctl_t zero, if_rdy, if_wait, id, id_ec;
  ctl_t ex_alu, wb_alu, ex_ldst, mem_ld, wb_ld, mem_st;
  ctl_t ex_br, br, ex_jal, ex_jalr;
  ctl_t h_plain, h_ill, h_merr;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECL  = 7'b1110011;
  localparam logic [6:0] LUI  = 7'b0110111;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .OPCODE_W(7), .MEM_TIMEOUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode),
    .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_ecall(is_ecall),
    .halted(halted), .illegal_inst(illegal_inst),
    .mem_error(mem_error), .state_o(state_o),
    .cycle_count(cycle_count), .instret(instret)
  );

  assign obs = {state_o, pc_write, ir_write, i_or_d,
                mem_read, mem_write, reg_write, wb_sel,
                alu_src_a, alu_src_b, alu_op, is_ecall,
                halted, illegal_inst, mem_error};

  function automatic ctl_t mk(
    input logic [2:0] st,
    input logic pcw, irw, iod, mr, mw, rw,
    input logic [1:0] wb, a, b, op,
    input logic ec, hlt, ill, merr);
    return {st, pcw, irw, iod, mr, mw, rw,
            wb, a, b, op, ec, hlt, ill, merr};
  endfunction

  task automatic step(input string tag, input ctl_t e);
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [CNT_W-1:0] o,
                     input logic [CNT_W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, o, e);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    zero    = '0;
    if_rdy  = mk(0,1,1,0,1,0,0, 0,0,1,0, 0,0,0,0);
    if_wait = mk(0,0,0,0,1,0,0, 0,0,1,0, 0,0,0,0);
    id      = mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    id_ec   = mk(1,0,0,0,0,0,0, 0,0,0,0, 1,0,0,0);
    ex_alu  = mk(2,0,0,0,0,0,0, 0,2,0,2, 0,0,0,0);
    wb_alu  = mk(4,0,0,0,0,0,1, 0,0,0,0, 0,0,0,0);
    ex_ldst = mk(2,0,0,0,0,0,0, 0,2,2,0, 0,0,0,0);
    mem_ld  = mk(3,0,0,1,1,0,0, 0,2,2,0, 0,0,0,0);
    wb_ld   = mk(4,0,0,0,0,0,1, 1,0,0,0, 0,0,0,0);
    mem_st  = mk(3,0,0,1,0,1,0, 0,2,2,0, 0,0,0,0);
    ex_br   = mk(2,0,0,0,0,0,0, 0,2,0,1, 0,0,0,0);
    br      = mk(5,1,0,0,0,0,0, 0,1,2,0, 0,0,0,0);
    ex_jal  = mk(2,1,0,0,0,0,1, 2,1,2,0, 0,0,0,0);
    ex_jalr = mk(2,1,0,0,0,0,1, 2,2,2,0, 0,0,0,0);
    h_plain = mk(6,0,0,0,0,0,0, 0,0,0,0, 0,1,0,0);
    h_ill   = mk(6,0,0,0,0,0,0, 0,0,0,0, 0,1,1,0);
    h_merr  = mk(6,0,0,0,0,0,0, 0,0,0,0, 0,1,0,1);

    reset_n = 1'b0; opcode = '0; bcond = 1'b0;
    halt_req = 1'b0; mem_ready = 1'b1;
    step("reset_out", zero);
    step("reset_out2", zero);
    reset_n = 1'b1;

    // ADD
    mem_ready = 1'b1; step("add_if", if_rdy);
    opcode = ADD; mem_ready = 1'b0;
    step("add_id", id);
    step("add_ex", ex_alu);
    step("add_wb", wb_alu);
`ifdef CTRL_PERF_CNT_EN
    chk("add_instret", instret, 1);
    chk("add_cycles", cycle_count, 4);
`else
    chk("add_instret", instret, 0);
    chk("add_cycles", cycle_count, 0);
`endif

    // LW with 3 wait cycles in MEM
    mem_ready = 1'b1; step("lw_if", if_rdy);
    opcode = LW; mem_ready = 1'b0;
    step("lw_id", id);
    step("lw_ex", ex_ldst);
    step("lw_mem1", mem_ld);
    step("lw_mem2", mem_ld);
    step("lw_mem3", mem_ld);
    mem_ready = 1'b1; step("lw_mem4", mem_ld);
    mem_ready = 1'b0; step("lw_wb", wb_ld);

    // BEQ not taken, then taken
    mem_ready = 1'b1; step("bnt_if", if_rdy);
    opcode = BEQ; mem_ready = 1'b0; bcond = 1'b0;
    step("bnt_id", id);
    step("bnt_ex", ex_br);
    mem_ready = 1'b1; step("bt_if", if_rdy);
    mem_ready = 1'b0; bcond = 1'b1;
    step("bt_id", id);
    step("bt_ex", ex_br);
    bcond = 1'b0;
    step("bt_br", br);

    // JAL, JALR
    mem_ready = 1'b1; step("jal_if", if_rdy);
    opcode = JAL; mem_ready = 1'b0;
    step("jal_id", id);
    step("jal_ex", ex_jal);
    mem_ready = 1'b1; step("jalr_if", if_rdy);
    opcode = JALR; mem_ready = 1'b0;
    step("jalr_id", id);
    step("jalr_ex", ex_jalr);

    // SW, zero wait
    mem_ready = 1'b1; step("sw_if", if_rdy);
    opcode = SW; mem_ready = 1'b0;
    step("sw_id", id);
    step("sw_ex", ex_ldst);
    mem_ready = 1'b1; step("sw_mem", mem_st);

    // ECALL, no halt
    step("ec_if", if_rdy);
    opcode = ECL; mem_ready = 1'b0;
    step("ec_id", id_ec);

    // IF waits 3 cycles, ready on the limit cycle
    step("to_w1", if_wait);
    step("to_w2", if_wait);
    step("to_w3", if_wait);
    mem_ready = 1'b1; step("to_w4_rdy", if_rdy);
    mem_ready = 1'b0; step("to_ec_id", id_ec);

    // Reset during SW MEM wait
    mem_ready = 1'b1; step("rs_if", if_rdy);
    opcode = SW; mem_ready = 1'b0;
    step("rs_id", id);
    step("rs_ex", ex_ldst);
    step("rs_mem", mem_st);
    reset_n = 1'b0;
    step("rs_abort", zero);
    step("rs_hold", zero);
    reset_n = 1'b1;
    chk("rs_instret", instret, 0);
    chk("rs_cycles", cycle_count, 0);
    step("rs_rel", if_wait);

    // Illegal opcode
    mem_ready = 1'b1; step("il_if", if_rdy);
    opcode = LUI; mem_ready = 1'b0;
    step("il_id", id);
    step("il_halt", h_ill);
    mem_ready = 1'b1; step("il_hold", h_ill);

    // ECALL with halt_req
    do_reset();
    mem_ready = 1'b1; step("eh_if", if_rdy);
    opcode = ECL; halt_req = 1'b1; mem_ready = 1'b0;
    step("eh_id", id_ec);
    halt_req = 1'b0;
    step("eh_halt", h_plain);
    mem_ready = 1'b1; step("eh_hold", h_plain);

    // IF timeout
    do_reset();
    mem_ready = 1'b0;
    step("tm_w1", if_wait);
    step("tm_w2", if_wait);
    step("tm_w3", if_wait);
    step("tm_w4", if_wait);
    step("tm_halt", h_merr);
    mem_ready = 1'b1; step("tm_hold", h_merr);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
